// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative RV32M divider.
package div_unit_pkg;

    typedef enum logic [2:0] {
        OP_DIV  = 3'b100,
        OP_DIVU = 3'b101,
        OP_REM  = 3'b110,
        OP_REMU = 3'b111
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int          DIV_ITERS     = 32;
    localparam logic [31:0] DIV_BY_ZERO_Q = '1;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract.
module div_step
    import div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic            quo_msb,
    input  logic [XLEN-1:0] dvsr,
    output logic [XLEN-1:0] rem_nxt,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    assign shifted = {rem, quo_msb};
    assign trial   = shifted - {1'b0, dvsr};
    // rem < dvsr on entry, so a non-negative trial always fits back into XLEN bits
    assign q_bit   = ~trial[XLEN];
    assign rem_nxt = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 DIV/DIVU/REM/REMU unit for the EXE stage; raises div_busy while computing.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      fun3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    input  logic            advance,
    output logic            div_busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    div_state_e      state;
    div_op_e         op;
    div_op_e         op_in;
    logic [4:0]      cnt;
    logic [XLEN-1:0] rem, quo, dvsr;
    logic            neg_q, neg_r;
    logic            accept, signed_in, rem_in, special;
    logic [XLEN-1:0] special_res, final_res, step_rem, q_final;
    logic            step_q;

    function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                  input logic sgn);
        logic signed [XLEN-1:0] n;
        n = -v;
        return (sgn && (v < 0)) ? $unsigned(n) : $unsigned(v);
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? (XLEN'(0) - v) : v;
    endfunction

    assign op_in     = div_op_e'(fun3);
    assign signed_in = (op_in == OP_DIV) || (op_in == OP_REM);
    assign rem_in    = (op_in == OP_REM) || (op_in == OP_REMU);
    assign accept    = (state == IDLE) && start && !flush;

    // Zero divisor and INT_MIN / -1 bypass the iteration entirely
    assign special = (op_b == '0) || (signed_in && (op_a == INT_MIN) && (op_b == '1));
    always_comb begin
        special_res = '0;
        if (op_b == '0) special_res = rem_in ? op_a : DIV_BY_ZERO_Q;
        else            special_res = rem_in ? '0 : INT_MIN;
    end

    div_step #(.XLEN(XLEN)) u_step (
        .rem     (rem),
        .quo_msb (quo[XLEN-1]),
        .dvsr    (dvsr),
        .rem_nxt (step_rem),
        .q_bit   (step_q)
    );

    assign q_final   = {quo[XLEN-2:0], step_q};
    assign final_res = ((op == OP_REM) || (op == OP_REMU)) ? neg_if(step_rem, neg_r)
                                                           : neg_if(q_final, neg_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (special) begin
                        state  <= DONE;
                        result <= special_res;
                    end else begin
                        state <= BUSY;
                        cnt   <= 5'(DIV_ITERS - 1);
                    end
                end
                BUSY: if (cnt == 5'd0) begin
                    state  <= DONE;
                    result <= final_res;
                end else begin
                    cnt <= cnt - 5'd1;
                end
                DONE: if (advance) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operand/iteration datapath
    always_ff @(posedge clk) begin
        if (accept) begin
            op    <= op_in;
            quo   <= magnitude(op_a, signed_in);
            dvsr  <= magnitude(op_b, signed_in);
            rem   <= '0;
            neg_q <= signed_in && (op_a[XLEN-1] ^ op_b[XLEN-1]);
            neg_r <= signed_in && op_a[XLEN-1];
        end else if (state == BUSY) begin
            rem <= step_rem;
            quo <= q_final;
        end
    end

    assign div_busy     = (((state == IDLE) && start) || (state == BUSY)) && !flush;
    assign result_valid = (state == DONE);

endmodule
